// File: rtl/bsw_seq_feeder_if.sv
// Feeder bus: packed word-pair upload side plus the base-pair stream and
// done/score handshake towards the BSW core.
interface bsw_seq_feeder_if #(
  parameter int MAX_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_s;
  logic [7:0]       in_t;
  logic             i_valid;
  logic [1:0]       data_s;
  logic [1:0]       data_t;
  logic             bsw_finish;
  logic [MAX_W-1:0] bsw_max;

  modport master (
    output in_valid, in_s, in_t, bsw_finish, bsw_max,
    input  in_ready, i_valid, data_s, data_t
  );

  modport slave (
    input  in_valid, in_s, in_t, bsw_finish, bsw_max,
    output in_ready, i_valid, data_s, data_t
  );
endinterface

// File: rtl/bsw_seq_feeder.sv
// Buffers SEQ_LEN/4 packed S/T word pairs, then streams them one base pair per
// cycle into a BSW core and captures its score. FEEDER_PINGPONG_EN adds a second bank.
module bsw_seq_feeder #(
  parameter int SEQ_LEN = 256,
  parameter int MAX_W   = 12
) (
  input  logic             clk,
  input  logic             reset,
  bsw_seq_feeder_if.slave  bus,
  output logic             res_valid,
  output logic [MAX_W-1:0] res_max,
  output logic             busy
);
  localparam int WORDS  = SEQ_LEN / 4;
  localparam int WAW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int BW     = $clog2(SEQ_LEN) + 1;
  localparam int STAGES = 2;
  localparam logic [BW-1:0]  LEN    = BW'(SEQ_LEN);
  localparam logic [WAW-1:0] LAST_W = WAW'(WORDS - 1);
`ifdef FEEDER_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, WAIT_DONE} state_t;

  state_t            state, nxt;
  logic [WAW-1:0]    wcnt;
  logic [BW-1:0]     bcnt;
  logic [STAGES:1]   vld_pipe;
  logic [1:0]        s1_s, s1_t;
  logic [7:0]        mem_s [NB][WORDS];
  logic [7:0]        mem_t [NB][WORDS];
  logic              wbank, rbank;
  logic              xfer, last_w, issue, pend_full, pend_part;
  logic [WAW-1:0]    rword;
  logic [1:0]        rsel;
  logic [7:0]        rd_s, rd_t;

  assign xfer   = bus.in_valid && bus.in_ready;
  assign last_w = (wcnt == LAST_W);
  assign issue  = (state == STREAM) && (bcnt < LEN);
  assign rword  = bcnt[WAW+1:2];
  assign rsel   = bcnt[1:0];
  assign rd_s   = mem_s[rbank][rword];
  assign rd_t   = mem_t[rbank][rword];
  assign busy   = (state != IDLE);
  assign bus.i_valid = vld_pipe[STAGES];

`ifdef FEEDER_PINGPONG_EN
  logic [1:0] full;

  // A bank is full from its last word until its job's finish; write and read
  // pointers each flip at those two events.
  always_ff @(posedge clk) begin
    if (reset) begin
      full  <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
    end else begin
      if (xfer && last_w) begin
        full[wbank] <= 1'b1;
        wbank       <= ~wbank;
      end
      if (state == WAIT_DONE && bus.bsw_finish) begin
        full[rbank] <= 1'b0;
        rbank       <= ~rbank;
      end
    end
  end

  assign bus.in_ready = !reset && !full[wbank];
  assign pend_full    = full[~rbank] || (xfer && last_w);
  assign pend_part    = (wcnt != '0) || xfer;
`else
  assign wbank        = 1'b0;
  assign rbank        = 1'b0;
  assign bus.in_ready = !reset && (state == IDLE || state == LOAD);
  assign pend_full    = 1'b0;
  assign pend_part    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (xfer) begin
      mem_s[wbank][wcnt] <= bus.in_s;
      mem_t[wbank][wcnt] <= bus.in_t;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Leave STREAM only once the last base has reached the output register.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (xfer) nxt = last_w ? STREAM : LOAD;
      LOAD:      if (xfer && last_w) nxt = STREAM;
      STREAM:    if (bcnt == LEN && !vld_pipe[1]) nxt = WAIT_DONE;
      WAIT_DONE: if (bus.bsw_finish) nxt = pend_full ? STREAM : (pend_part ? LOAD : IDLE);
      default:   nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt       <= '0;
      bcnt       <= '0;
      vld_pipe   <= '0;
      s1_s       <= '0;
      s1_t       <= '0;
      bus.data_s <= '0;
      bus.data_t <= '0;
      res_valid  <= 1'b0;
      res_max    <= '0;
    end else begin
      if (xfer) wcnt <= last_w ? '0 : wcnt + 1'b1;
      if (nxt == STREAM && state != STREAM) bcnt <= '0;
      else if (issue)                       bcnt <= bcnt + 1'b1;
      // Stage 1 picks the base out of the word, stage 2 drives the core.
      vld_pipe   <= {vld_pipe[STAGES-1:1], issue};
      s1_s       <= issue ? rd_s[{rsel, 1'b0} +: 2] : 2'b00;
      s1_t       <= issue ? rd_t[{rsel, 1'b0} +: 2] : 2'b00;
      bus.data_s <= vld_pipe[1] ? s1_s : 2'b00;
      bus.data_t <= vld_pipe[1] ? s1_t : 2'b00;
      res_valid  <= (state == WAIT_DONE) && bus.bsw_finish;
      if (state == WAIT_DONE && bus.bsw_finish) res_max <= bus.bsw_max;
    end
  end
endmodule

// File: tb/tb_bsw_seq_feeder.sv
// Bench for bsw_seq_feeder: job table plus hand sequences; streamed bases are
// checked against a scoreboard filled as words are accepted.
module tb_bsw_seq_feeder;
  localparam int SEQ_LEN = 256;
  localparam int MAX_W   = 12;
  localparam int WORDS   = SEQ_LEN / 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             res_valid;
  logic [MAX_W-1:0] res_max;
  logic             busy;

  bsw_seq_feeder_if #(.MAX_W(MAX_W)) bus();

  bsw_seq_feeder #(.SEQ_LEN(SEQ_LEN), .MAX_W(MAX_W)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .res_valid(res_valid), .res_max(res_max), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_cmp = 0, n_bad = 0;
  logic [3:0] sb[$];
  bit         in_run = 0, lat_armed = 0;
  int         run_len = 0, runs_done = 0, last_acc = 0;

  typedef struct {
    logic [7:0]       s, t;
    bit               rnd, tgl;
    logic [MAX_W-1:0] mx, exp_res;
  } job_t;
  job_t jobs[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stream monitor: every valid base pops the scoreboard, every idle cycle must be zero.
  always @(negedge clk) begin : mon
    logic [3:0] e;
    if (reset) begin
      sb.delete();
      in_run    = 0;
      run_len   = 0;
      lat_armed = 0;
    end else if (bus.i_valid) begin
      if (!in_run) begin
        in_run  = 1;
        run_len = 0;
        if (lat_armed) begin
          chk("first_valid_latency", cyc - last_acc, 2);
          lat_armed = 0;
        end
      end
      if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("base_pair", {bus.data_s, bus.data_t}, e);
      end
      run_len++;
    end else begin
      chk("idle_data_zero", {bus.data_s, bus.data_t}, 0);
      if (in_run) begin
        chk("stream_len", run_len, SEQ_LEN);
        in_run = 0;
        runs_done++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_job(input logic [7:0] s0, input logic [7:0] t0, input bit rnd,
                          input bit tgl, input bit arm, output int ncyc);
    int acc;
    logic [7:0] s, t;
    bit drv, ok;
    acc = 0; ncyc = 0;
    s = rnd ? 8'($urandom) : s0;
    t = rnd ? 8'($urandom) : t0;
    while (acc < WORDS && ncyc < 4 * WORDS + 64) begin
      drv = !(tgl && ncyc[0]);
      bus.in_valid = drv;
      bus.in_s = drv ? s : 8'($urandom);
      bus.in_t = drv ? t : 8'($urandom);
      @(negedge clk);
      ok = drv && bus.in_ready;
      tick();
      ncyc++;
      if (ok) begin
        for (int b = 0; b < 4; b++) sb.push_back({s[2*b +: 2], t[2*b +: 2]});
        acc++;
        if (acc == WORDS && arm) begin
          last_acc  = cyc;
          lat_armed = 1;
        end
        s = rnd ? 8'($urandom) : s0;
        t = rnd ? 8'($urandom) : t0;
      end
    end
    bus.in_valid = 1'b0;
    chk("load_words", acc, WORDS);
  endtask

  task automatic wait_runs(input int target);
    int n;
    n = 0;
    while (runs_done < target && n < 3000) begin
      tick();
      n++;
    end
    chk("stream_complete", runs_done, target);
  endtask

  task automatic finish_pulse(input logic [MAX_W-1:0] mx, output int fedge);
    bus.bsw_finish = 1'b1;
    bus.bsw_max    = mx;
    tick();
    fedge          = cyc;
    bus.bsw_finish = 1'b0;
    bus.bsw_max    = MAX_W'($urandom);
  endtask

  initial begin : timeout
    #2000000;
    n_bad++;
    $display("FAIL global_timeout: actual=running required=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : main
    int n, f, w;
    bus.in_valid = 0; bus.in_s = 0; bus.in_t = 0;
    bus.bsw_finish = 0; bus.bsw_max = 0;
    jobs[0] = '{8'hE4, 8'h1B, 1'b0, 1'b0, 12'd517, 12'd517};
    jobs[1] = '{8'hFF, 8'h00, 1'b0, 1'b0, 12'd0,   12'd0};
    jobs[2] = '{8'h00, 8'h00, 1'b1, 1'b1, 12'hFFF, 12'hFFF};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_i_valid", bus.i_valid, 0);
    chk("rst_data", {bus.data_s, bus.data_t}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_max", res_max, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", bus.in_ready, 1);
    tick();

    for (int i = 0; i < 3; i++) begin
      load_job(jobs[i].s, jobs[i].t, jobs[i].rnd, jobs[i].tgl, 1'b1, n);
`ifndef FEEDER_PINGPONG_EN
      // Offers while not ready must be refused and leave the stream intact.
      for (int k = 0; k < 3; k++) begin
        bus.in_valid = 1'b1;
        bus.in_s = 8'($urandom);
        bus.in_t = 8'($urandom);
        @(negedge clk);
        chk("in_ready_stream", bus.in_ready, 0);
        tick();
      end
      bus.in_valid = 1'b0;
`endif
      wait_runs(i + 1);
      @(negedge clk);
      chk("wait_busy", busy, 1);
      chk("no_early_res", res_valid, 0);
      finish_pulse(jobs[i].mx, f);
      @(negedge clk);
      chk("res_valid_pulse", res_valid, 1);
      chk("res_max", res_max, jobs[i].exp_res);
      chk("idle_busy", busy, 0);
      chk("idle_in_ready", bus.in_ready, 1);
      @(negedge clk);
      chk("res_valid_single", res_valid, 0);
      chk("res_max_hold", res_max, jobs[i].exp_res);
      tick();
    end

    // Finish outside WAIT_DONE is ignored.
    finish_pulse(12'd99, f);
    @(negedge clk);
    chk("idle_finish_no_res", res_valid, 0);
    chk("idle_finish_res_max", res_max, 12'hFFF);
    chk("idle_finish_busy", busy, 0);
    tick();

    // Reset in the middle of a stream, then a clean reload.
    load_job(8'hE4, 8'h1B, 1'b0, 1'b0, 1'b1, n);
    w = 0;
    while (!(in_run && run_len >= 100) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("reach_base_100", run_len >= 100, 1);
    @(posedge clk); #1 reset = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_i_valid", bus.i_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_res_max", res_max, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", bus.in_ready, 1);
    tick();
    load_job(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, n);
    wait_runs(4);
    @(negedge clk);
    finish_pulse(12'd300, f);
    @(negedge clk);
    chk("reload_res_valid", res_valid, 1);
    chk("reload_res_max", res_max, 300);
    tick();

`ifdef FEEDER_PINGPONG_EN
    // Second job loads while the first streams, then follows with no IDLE gap.
    load_job(8'hE4, 8'h1B, 1'b0, 1'b0, 1'b1, n);
    w = 0;
    while (!bus.i_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("pp_in_ready_stream", bus.in_ready, 1);
    tick();
    load_job(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, n);
    chk("pp_load_cycles", n, WORDS);
    @(negedge clk);
    chk("pp_both_full", bus.in_ready, 0);
    tick();
    wait_runs(5);
    @(negedge clk);
    finish_pulse(12'd1234, f);
    last_acc  = f;
    lat_armed = 1;
    @(negedge clk);
    chk("pp_res_valid_a", res_valid, 1);
    chk("pp_res_max_a", res_max, 1234);
    chk("pp_busy_kept", busy, 1);
    tick();
    wait_runs(6);
    @(negedge clk);
    finish_pulse(12'd42, f);
    @(negedge clk);
    chk("pp_res_max_b", res_max, 42);
    chk("pp_busy_end", busy, 0);
    tick();
`endif

    repeat (5) tick();
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bsw_seq_feeder.md
BSW_SEQ_FEEDER -- requirements
Module: bsw_seq_feeder

Interface
REQ-001 Parameter SEQ_LEN, 256, bases per sequence; SHALL be a multiple of 4.
REQ-002 Parameter MAX_W, 12, width of the BSW score.
REQ-003 Port clk input 1: single clock; all state SHALL change on its rising edge.
REQ-004 Port reset input 1: synchronous, active-high reset.
REQ-005 Port in_valid input 1: a packed word pair is offered.
REQ-006 Port in_ready output 1: the feeder accepts the word pair this cycle.
REQ-007 Port in_s input 8: four bases of sequence S; bits [1:0] are the earliest base, [7:6] the latest.
REQ-008 Port in_t input 8: four bases of sequence T, same packing as in_s.
REQ-009 Port i_valid output 1: base-pair stream valid, to the BSW core.
REQ-010 Port data_s output 2: S base to the BSW core.
REQ-011 Port data_t output 2: T base to the BSW core.
REQ-012 Port bsw_finish input 1: BSW core done pulse.
REQ-013 Port bsw_max input MAX_W: BSW core score, valid while bsw_finish=1.
REQ-014 Port res_valid output 1: one-cycle result pulse.
REQ-015 Port res_max output MAX_W: captured score.
REQ-016 Port busy output 1: high in any state other than IDLE.

Function
REQ-017 A transfer SHALL occur when in_valid=1 and in_ready=1 in the same cycle; the word pair SHALL be written to buffer entry wcnt, and wcnt SHALL increment.
REQ-018 FSM states SHALL be IDLE, LOAD, STREAM and WAIT_DONE.
- IDLE -> LOAD on the first transfer.
- LOAD -> STREAM on the cycle after transfer number SEQ_LEN/4.
- STREAM -> WAIT_DONE after the last base is driven.
- WAIT_DONE -> IDLE on bsw_finish.
REQ-019 in_ready SHALL be 1 in IDLE and LOAD, and 0 in STREAM and WAIT_DONE (single-bank build).
REQ-020 In STREAM, i_valid SHALL be 1 for exactly SEQ_LEN consecutive cycles with no gaps; data_s/data_t SHALL be registered outputs.
REQ-021 Streamed base n SHALL be bits [2*(n%4)+1 : 2*(n%4)] of buffer word n/4.
REQ-022 The first i_valid=1 cycle SHALL be 2 cycles after the clock edge that accepts the final word.
REQ-023 data_s and data_t SHALL be 0 whenever i_valid=0.
REQ-024 On bsw_finish=1 in WAIT_DONE, the feeder SHALL capture bsw_max into res_max and pulse res_valid for exactly 1 cycle on the next cycle.
REQ-025 bsw_finish outside WAIT_DONE SHALL be ignored: no res_valid, res_max unchanged.
REQ-026 res_max SHALL hold its value until the next capture.
REQ-027 in_valid while in_ready=0 SHALL be ignored; upstream holds its data.
REQ-028 The base counter SHALL be clog2(SEQ_LEN)+1 bits wide and SHALL NOT wrap during STREAM.

Reset
REQ-029 While reset=1 at a clock edge:
- state SHALL go to IDLE, and wcnt and the base counter SHALL clear;
- i_valid, data_s, data_t, res_valid, res_max and busy SHALL be 0;
- in_ready SHALL be 0, then 1 in the first cycle after reset deasserts.
REQ-030 Reset mid-LOAD or mid-STREAM SHALL abandon the sequence: i_valid SHALL be 0 from the following cycle, and the next load SHALL restart at word 0.
REQ-031 Buffer contents need not be cleared.

Configuration
REQ-032 Macro FEEDER_PINGPONG_EN SHALL enable the ping-pong buffering feature.
REQ-033 With FEEDER_PINGPONG_EN defined:
- the buffer SHALL have two banks;
- in_ready SHALL stay 1 in STREAM and WAIT_DONE while the other bank is not full;
- a full pending bank SHALL start STREAM on the cycle after WAIT_DONE exits, with no return to IDLE;
- busy SHALL stay 1 across back-to-back jobs.
REQ-034 Without FEEDER_PINGPONG_EN, the block SHALL use a single bank and behave exactly as REQ-019.

Verification
REQ-035 Reset, then 64 words with in_s=8'hE4 and in_t=8'h1B -> 256 i_valid cycles; data_s sequence 0,1,2,3 repeating; data_t sequence 3,2,1,0 repeating.
REQ-036 in_valid toggling 1/0 during LOAD (128 cycles total) -> stream still contiguous; first i_valid 2 cycles after the 64th accepted word.
REQ-037 bsw_finish with bsw_max=12'd517 in WAIT_DONE -> res_valid=1 for 1 cycle with res_max=517, then IDLE, in_ready=1, busy=0.
REQ-038 bsw_finish pulse in IDLE with bsw_max=12'd99 -> no res_valid; res_max unchanged.
REQ-039 reset asserted at stream base 100 -> i_valid=0 the next cycle; a fresh 64-word load streams correctly from base 0.
REQ-040 (FEEDER_PINGPONG_EN) Load a second job during the first STREAM -> second stream begins the cycle after the first job's WAIT_DONE exit, with in_ready=1 during the first STREAM.
